// File: rtl/tl_acquire_to_axi_if.sv
// Bundles the TileLink Acquire beat stream with the AXI4 AW, W and AR channels.
// The master modport is the bridge side; the slave modport is the queue/AXI fabric side.
interface tl_acquire_to_axi_if #(
    parameter int ADDR_W = 32
) ();
    logic              acq_ready;
    logic              acq_valid;
    logic [25:0]       acq_addr_block;
    logic [1:0]        acq_client_xact_id;
    logic [2:0]        acq_addr_beat;
    logic              acq_is_builtin_type;
    logic [2:0]        acq_a_type;
    logic [11:0]       acq_union;
    logic [63:0]       acq_data;

    logic              aw_valid;
    logic              aw_ready;
    logic [ADDR_W-1:0] aw_addr;
    logic [1:0]        aw_id;
    logic [7:0]        aw_len;
    logic [2:0]        aw_size;
    logic [1:0]        aw_burst;

    logic              w_valid;
    logic              w_ready;
    logic [63:0]       w_data;
    logic [7:0]        w_strb;
    logic              w_last;

    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic [1:0]        ar_id;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;

    modport master (
        output acq_ready,
        input  acq_valid, acq_addr_block, acq_client_xact_id, acq_addr_beat,
               acq_is_builtin_type, acq_a_type, acq_union, acq_data,
        output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
        input  ar_ready
    );

    modport slave (
        input  acq_ready,
        output acq_valid, acq_addr_block, acq_client_xact_id, acq_addr_beat,
               acq_is_builtin_type, acq_a_type, acq_union, acq_data,
        input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
        output ar_ready
    );
endinterface

// File: rtl/tl_acquire_to_axi.sv
// Converts built-in TileLink Acquires (Get/GetBlock/Put/PutBlock) into AXI4 AR or AW+W bursts.
// Optional macro ACQ_BEAT_CHECK_EN adds a sticky check of acq_addr_beat against the W beat count.
//
//  state | meaning
//  IDLE  | decode queue head; drop unsupported Acquires with an err_type pulse
//  AR    | ar_valid held; Acquire consumed on the AR handshake
//  AW    | aw_valid held; beat 0 stays at the queue head
//  W     | stream beats from the queue head until w_last handshakes
module tl_acquire_to_axi #(
    parameter int ADDR_W      = 32,
    parameter int BLOCK_BEATS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    tl_acquire_to_axi_if.master     bus,
    output logic                    err_type,
    output logic                    err_beat
);
    localparam logic [2:0] LAST_BEAT = 3'(BLOCK_BEATS - 1);
    localparam logic [7:0] BLOCK_LEN = 8'(BLOCK_BEATS - 1);

    typedef enum logic [1:0] {IDLE, AR, AW, W} state_t;

    state_t     state, state_nxt;
    logic       is_block_q, is_block_nxt;
    logic [2:0] beat_cnt, beat_cnt_nxt;

    logic        supported;
    logic        last_beat;
    logic        w_hs;
    logic [31:0] addr_raw;
    logic [ADDR_W-1:0] addr;
    logic [7:0]  len;
    logic        unused_union;

    assign supported    = bus.acq_is_builtin_type && !bus.acq_a_type[2];
    assign last_beat    = !is_block_q || (beat_cnt == LAST_BEAT);
    assign w_hs         = (state == W) && reset && bus.acq_valid && bus.w_ready;
    assign unused_union = ^{bus.acq_union[11:9], bus.acq_union[0]};

    // Block transfers always start at beat 0 of the block.
    assign addr_raw = {bus.acq_addr_block, (is_block_q ? 3'b000 : bus.acq_addr_beat), 3'b000};
    assign len      = is_block_q ? BLOCK_LEN : 8'd0;

    generate
        if (ADDR_W > 32) begin : g_addr_ext
            assign addr = {{(ADDR_W - 32){1'b0}}, addr_raw};
        end else begin : g_addr_trunc
            assign addr = addr_raw[ADDR_W-1:0];
        end
    endgenerate

    assign bus.aw_addr  = addr;
    assign bus.aw_id    = bus.acq_client_xact_id;
    assign bus.aw_len   = len;
    assign bus.aw_size  = 3'd3;
    assign bus.aw_burst = 2'd1;
    assign bus.ar_addr  = addr;
    assign bus.ar_id    = bus.acq_client_xact_id;
    assign bus.ar_len   = len;
    assign bus.ar_size  = 3'd3;
    assign bus.ar_burst = 2'd1;
    assign bus.w_data   = bus.acq_data;
    assign bus.w_strb   = is_block_q ? 8'hFF : bus.acq_union[8:1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            is_block_q <= 1'b0;
            beat_cnt   <= 3'd0;
        end else begin
            state      <= state_nxt;
            is_block_q <= is_block_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        is_block_nxt  = is_block_q;
        beat_cnt_nxt  = beat_cnt;
        bus.acq_ready = 1'b0;
        bus.aw_valid  = 1'b0;
        bus.w_valid   = 1'b0;
        bus.w_last    = 1'b0;
        bus.ar_valid  = 1'b0;
        err_type      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.acq_valid) begin
                    if (!supported) begin
                        bus.acq_ready = 1'b1;
                        err_type      = 1'b1;
                    end else begin
                        is_block_nxt = bus.acq_a_type[0];
                        state_nxt    = bus.acq_a_type[1] ? AW : AR;
                    end
                end
            end
            AR: begin
                bus.ar_valid  = 1'b1;
                bus.acq_ready = bus.ar_ready;
                if (bus.ar_ready) state_nxt = IDLE;
            end
            AW: begin
                bus.aw_valid = 1'b1;
                if (bus.aw_ready) state_nxt = W;
            end
            W: begin
                bus.w_valid   = bus.acq_valid;
                bus.acq_ready = bus.w_ready;
                bus.w_last    = last_beat;
                if (bus.acq_valid && bus.w_ready) begin
                    if (last_beat) begin
                        beat_cnt_nxt = 3'd0;
                        state_nxt    = IDLE;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 3'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Handshake outputs are held quiet for as long as reset is asserted.
        if (!reset) begin
            bus.acq_ready = 1'b0;
            bus.aw_valid  = 1'b0;
            bus.w_valid   = 1'b0;
            bus.w_last    = 1'b0;
            bus.ar_valid  = 1'b0;
            err_type      = 1'b0;
        end
    end

`ifdef ACQ_BEAT_CHECK_EN
    logic err_beat_q;

    // Single-beat Puts carry an arbitrary beat index, so only block beats are checked.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_beat_q <= 1'b0;
        end else if (w_hs && is_block_q && (bus.acq_addr_beat != beat_cnt)) begin
            err_beat_q <= 1'b1;
        end
    end

    assign err_beat = err_beat_q;
`else
    logic unused_w_hs;

    assign unused_w_hs = w_hs;
    assign err_beat    = 1'b0;
`endif
endmodule

// File: tb/tb_tl_acquire_to_axi.sv
// Directed bench for tl_acquire_to_axi: reset, Get/GetBlock, Put/PutBlock, unsupported drop, mid-burst reset.
module tb_tl_acquire_to_axi;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic err_type, err_beat;
    int   n_pass = 0;
    int   n_total = 0;
    int   hs, lasts;

    tl_acquire_to_axi_if #(.ADDR_W(ADDR_W)) bus ();

    tl_acquire_to_axi #(.ADDR_W(ADDR_W), .BLOCK_BEATS(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .err_type (err_type),
        .err_beat (err_beat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_acq(input logic v, input logic b, input logic [2:0] t, input logic [25:0] blk,
                           input logic [2:0] beat, input logic [1:0] id, input logic [11:0] un,
                           input logic [63:0] d);
        bus.acq_valid           = v;
        bus.acq_is_builtin_type = b;
        bus.acq_a_type          = t;
        bus.acq_addr_block      = blk;
        bus.acq_addr_beat       = beat;
        bus.acq_client_xact_id  = id;
        bus.acq_union           = un;
        bus.acq_data            = d;
    endtask

    // Streams W beats from state W; beat index bad carries addr_beat=4 instead of its index.
    task automatic run_w(input int nb, input bit toggle, input int bad,
                         output int n_hs, output int n_last);
        n_hs   = 0;
        n_last = 0;
        for (int i = 0; i < 4 * nb && n_hs < nb; i++) begin
            bus.w_ready       = toggle ? (i % 2 == 0) : 1'b1;
            bus.acq_addr_beat = (n_hs == bad) ? 3'd4 : 3'(n_hs);
            bus.acq_data      = 64'hD000 + 64'(n_hs);
            #1;
            chk("w_valid", bus.w_valid, 1);
            chk("w_last", bus.w_last, n_hs == 7);
            chk("w_strb", bus.w_strb, 8'hFF);
            chk("w_data", bus.w_data, 64'hD000 + 64'(n_hs));
            chk("acq_ready_w", bus.acq_ready, bus.w_ready);
            if (bus.w_valid && bus.w_ready) begin
                n_hs++;
                if (bus.w_last) n_last++;
            end
            tick();
        end
    endtask

    initial begin
        bus.aw_ready = 1'b0;
        bus.w_ready  = 1'b0;
        bus.ar_ready = 1'b0;
        set_acq(1, 1, 3'd5, 26'h0, 3'd0, 2'd0, 12'h0, 64'h0);

        // Reset with an unsupported Acquire pending: everything must stay quiet.
        tick();
        tick();
        chk("rst_valids", {bus.ar_valid, bus.aw_valid, bus.w_valid}, 3'b000);
        chk("rst_acq_ready", bus.acq_ready, 0);
        chk("rst_err_type", err_type, 0);
        chk("rst_err_beat", err_beat, 0);
        bus.acq_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("idle_valids", {bus.ar_valid, bus.aw_valid, bus.w_valid}, 3'b000);

        // GetBlock, block 0x40, id 2, beat 5 (forced to 0 in the address).
        bus.ar_ready = 1'b1;
        set_acq(1, 1, 3'd1, 26'h40, 3'd5, 2'd2, 12'h0, 64'h0);
        #1;
        chk("gb_idle_acq_ready", bus.acq_ready, 0);
        chk("gb_idle_ar_valid", bus.ar_valid, 0);
        tick();
        chk("gb_ar_valid", bus.ar_valid, 1);
        chk("gb_ar_addr", bus.ar_addr, 32'h0000_1000);
        chk("gb_ar_len", bus.ar_len, 8'd7);
        chk("gb_ar_id", bus.ar_id, 2'd2);
        chk("gb_ar_size_burst", {bus.ar_size, bus.ar_burst}, {3'd3, 2'd1});
        chk("gb_acq_ready", bus.acq_ready, 1);
        chk("gb_aw_valid", bus.aw_valid, 0);
        tick();
        bus.acq_valid = 1'b0;
        #1;
        chk("gb_done", bus.ar_valid, 0);

        // Put, block 0x12, beat 3, strb 0x0F; AW held across one stalled cycle.
        bus.ar_ready = 1'b0;
        set_acq(1, 1, 3'd2, 26'h12, 3'd3, 2'd1, 12'h01E, 64'h1122334455667788);
        tick();
        chk("p_aw_valid", bus.aw_valid, 1);
        chk("p_aw_addr", bus.aw_addr, 32'h0000_0498);
        chk("p_aw_len", bus.aw_len, 8'd0);
        chk("p_aw_id", bus.aw_id, 2'd1);
        chk("p_acq_ready", bus.acq_ready, 0);
        chk("p_w_before_aw", bus.w_valid, 0);
        tick();
        chk("p_aw_hold", bus.aw_valid, 1);
        chk("p_aw_addr_hold", bus.aw_addr, 32'h0000_0498);
        bus.aw_ready = 1'b1;
        tick();
        bus.aw_ready = 1'b0;
        bus.w_ready  = 1'b1;
        #1;
        chk("p_aw_dropped", bus.aw_valid, 0);
        chk("p_w_valid", bus.w_valid, 1);
        chk("p_w_data", bus.w_data, 64'h1122334455667788);
        chk("p_w_strb", bus.w_strb, 8'h0F);
        chk("p_w_last", bus.w_last, 1);
        chk("p_acq_ready", bus.acq_ready, 1);
        tick();
        bus.acq_valid = 1'b0;
        #1;
        chk("p_done", bus.w_valid, 0);

        // PutBlock, block 0x3, union that would give a wrong strb if used.
        bus.aw_ready = 1'b1;
        set_acq(1, 1, 3'd3, 26'h3, 3'd0, 2'd0, 12'hAAA, 64'hD000);
        tick();
        chk("pb_aw_valid", bus.aw_valid, 1);
        chk("pb_aw_addr", bus.aw_addr, 32'h0000_00C0);
        chk("pb_aw_len", bus.aw_len, 8'd7);
        tick();
        bus.aw_ready = 1'b0;
        run_w(8, 1, -1, hs, lasts);
        chk("pb_hs_count", hs, 8);
        chk("pb_last_count", lasts, 1);

        // New Get presented right after the last beat: one-cycle bubble in IDLE.
        bus.ar_ready = 1'b1;
        bus.w_ready  = 1'b0;
        set_acq(1, 1, 3'd0, 26'h5, 3'd2, 2'd3, 12'h0, 64'h0);
        #1;
        chk("bub_valids", {bus.ar_valid, bus.aw_valid, bus.w_valid}, 3'b000);
        chk("bub_acq_ready", bus.acq_ready, 0);
        tick();
        chk("g_ar_valid", bus.ar_valid, 1);
        chk("g_ar_addr", bus.ar_addr, 32'h0000_0150);
        chk("g_ar_len", bus.ar_len, 8'd0);
        chk("g_ar_id", bus.ar_id, 2'd3);
        tick();
        bus.acq_valid = 1'b0;
        bus.ar_ready  = 1'b0;

        // Unsupported: a_type 5, then a non-builtin Acquire.
        set_acq(1, 1, 3'd5, 26'h7, 3'd0, 2'd0, 12'h0, 64'h0);
        #1;
        chk("u5_err_type", err_type, 1);
        chk("u5_acq_ready", bus.acq_ready, 1);
        chk("u5_valids", {bus.ar_valid, bus.aw_valid, bus.w_valid}, 3'b000);
        tick();
        bus.acq_valid = 1'b0;
        #1;
        chk("u5_pulse_end", err_type, 0);
        chk("u5_valids_after", {bus.ar_valid, bus.aw_valid, bus.w_valid}, 3'b000);
        set_acq(1, 0, 3'd0, 26'h7, 3'd0, 2'd0, 12'h0, 64'h0);
        #1;
        chk("nb_err_type", err_type, 1);
        tick();
        bus.acq_valid = 1'b0;
        #1;
        chk("nb_pulse_end", err_type, 0);

        // PutBlock with beat 2 carrying addr_beat=4, then reset after beat 3.
        bus.aw_ready = 1'b1;
        set_acq(1, 1, 3'd3, 26'h9, 3'd0, 2'd0, 12'h0, 64'hD000);
        tick();
        tick();
        bus.aw_ready = 1'b0;
        run_w(4, 0, 2, hs, lasts);
        chk("mb_hs_count", hs, 4);
`ifdef ACQ_BEAT_CHECK_EN
        chk("mb_err_beat_set", err_beat, 1);
`else
        chk("mb_err_beat_tied", err_beat, 0);
`endif
        reset = 1'b0;
        #1;
        chk("mb_rst_valids", {bus.ar_valid, bus.aw_valid, bus.w_valid}, 3'b000);
        chk("mb_rst_acq_ready", bus.acq_ready, 0);
        tick();
        chk("mb_rst_err_beat", err_beat, 0);
        reset = 1'b1;
        bus.acq_addr_beat = 3'd0;
        bus.aw_ready      = 1'b1;
        tick();
        chk("mb_restart_aw", bus.aw_valid, 1);
        tick();
        bus.aw_ready = 1'b0;
        run_w(8, 0, -1, hs, lasts);
        chk("mb_restart_hs", hs, 8);
        chk("mb_restart_last", lasts, 1);
        bus.acq_valid = 1'b0;
        #1;
        chk("mb_final_idle", {bus.ar_valid, bus.aw_valid, bus.w_valid}, 3'b000);
        chk("mb_final_err_beat", err_beat, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
